// File: rtl/exp5_unidade_controle.sv
// exp5_unidade_controle: Moore control FSM for a memory-play round; optional timeout via EXP5_TIMEOUT_EN
module exp5_unidade_controle #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h4,
    COMPARACAO    = 4'h5,
    PROXIMO       = 4'h6,
    FIM_ACERTO    = 4'hA,
    FIM_TIMEOUT   = 4'hD,
    FIM_ERRO      = 4'hE
  } t_estado;
  t_estado r_estado, w_proximo;
  logic    w_expirou;
`ifdef EXP5_TIMEOUT_EN
  logic [15:0] r_cnt;
  // counts cycles spent waiting for a play; cleared whenever the FSM is elsewhere
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_cnt <= '0;
    else r_cnt <= (r_estado == ESPERA_JOGADA) ? r_cnt + 16'd1 : 16'd0;
  assign w_expirou = (r_cnt == 16'(TIMEOUT_CICLOS - 1));
  assign timeout   = (r_estado == FIM_TIMEOUT);
`else
  assign w_expirou = 1'b0;
  assign timeout   = 1'b0;
`endif
  // state register; reset aborts any round in progress
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_estado <= INICIAL;
    else r_estado <= w_proximo;
  // next-state logic; a play arriving on the expiry cycle takes priority over timeout
  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:       w_proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:    w_proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: w_proximo = jogada_feita ? REGISTRA : w_expirou ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA:      w_proximo = COMPARACAO;
      COMPARACAO:    w_proximo = !igual ? FIM_ERRO : fimC ? FIM_ACERTO : PROXIMO;
      PROXIMO:       w_proximo = ESPERA_JOGADA;
      FIM_ACERTO,
      FIM_TIMEOUT,
      FIM_ERRO:      w_proximo = iniciar ? PREPARACAO : r_estado;
      default:       w_proximo = INICIAL;
    endcase
  end
  assign zeraC     = (r_estado == PREPARACAO);
  assign zeraR     = (r_estado == PREPARACAO);
  assign registraR = (r_estado == REGISTRA);
  assign contaC    = (r_estado == PROXIMO);
  assign acertou   = (r_estado == FIM_ACERTO);
  assign errou     = (r_estado == FIM_ERRO);
  assign pronto    = (r_estado == FIM_ACERTO) || (r_estado == FIM_ERRO) || (r_estado == FIM_TIMEOUT);
  assign db_estado = r_estado;
endmodule

// File: tb/tb_exp5_unidade_controle.sv
// tb_exp5_unidade_controle: randomized round-level checks of the control FSM against outcome arithmetic
module tb_exp5_unidade_controle;
  localparam int TO = 8;
  logic clock = 0, reset = 0, iniciar = 0, jogada_feita = 0, igual = 0, fimC = 0;
  logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  int tests = 0, fails = 0, ncont = 0, cyc = 0, last_j = -100;

  exp5_unidade_controle #(.TIMEOUT_CICLOS(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
    .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
    .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (contaC) begin
      ncont++;
      chk("latency", cyc - last_j, 3);
    end
    chk("exclusive", 32'($countones({acertou, errou, timeout}) <= 1), 1);
  endtask

  task automatic play(input bit eq, input bit fim, input int gap);
    repeat (gap) begin
      tick();
      chk("espera", {zeraC, zeraR, contaC, registraR, db_estado}, 8'h02);
    end
    igual = eq;
    fimC = fim;
    jogada_feita = 1;
    last_j = cyc;
    tick();
    jogada_feita = 0;
    chk("registra", {registraR, contaC, db_estado}, {2'b10, 4'h4});
    tick();
    chk("comparacao", {registraR, db_estado}, {1'b0, 4'h5});
    tick();
  endtask

  task automatic round(input int m);
    int plays;
    plays = (m <= 16) ? m : 16;
    ncont = 0;
    iniciar = 1;
    tick();
    iniciar = 0;
    chk("prep", {zeraC, zeraR, pronto, acertou, errou, timeout, db_estado}, {6'b110000, 4'h1});
    tick();
    chk("espera0", {zeraC, zeraR, db_estado}, {2'b00, 4'h2});
    for (int k = 1; k <= plays; k++) begin
      play(k != m, k == 16, $urandom_range(0, 3));
      if (k < plays) begin
        chk("proximo", {contaC, pronto, db_estado}, {2'b10, 4'h6});
        tick();
        chk("volta", {contaC, db_estado}, {1'b0, 4'h2});
      end
    end
    chk("fim", {pronto, acertou, errou, timeout, db_estado},
        (m <= 16) ? {4'b1010, 4'hE} : {4'b1100, 4'hA});
    chk("ncont", ncont, plays - 1);
    repeat (3) begin
      tick();
      chk("hold", {pronto, acertou, errou, timeout, db_estado},
          (m <= 16) ? {4'b1010, 4'hE} : {4'b1100, 4'hA});
    end
  endtask

  initial begin
    #1;
    chk("reset_async", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado}, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_held", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado}, 0);
    @(negedge clock);
    reset = 1;
    tick();
    chk("inicial_idle", db_estado, 0);
    round(17);
    round(3);
    round(16);
    for (int r = 0; r < 6; r++) round($urandom_range(1, 20));
    iniciar = 1;
    tick();
    iniciar = 0;
    chk("restart_errou0", {errou, db_estado}, {1'b0, 4'h1});
    tick();
    igual = 1;
    fimC = 0;
    jogada_feita = 1;
    last_j = cyc;
    tick();
    jogada_feita = 0;
    tick();
    chk("pre_abort", db_estado, 5);
    #2 reset = 0;
    #1;
    chk("abort", {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado}, 0);
    @(negedge clock);
    reset = 1;
    tick();
    chk("after_abort", db_estado, 0);
    ncont = 0;
    iniciar = 1;
    tick();
    iniciar = 0;
    chk("abort_restart", {zeraC, zeraR, db_estado}, {2'b11, 4'h1});
    tick();
`ifdef EXP5_TIMEOUT_EN
    repeat (TO - 1) begin
      tick();
      chk("to_wait", db_estado, 2);
    end
    tick();
    chk("to_fim", {pronto, acertou, errou, timeout, db_estado}, {4'b1001, 4'hD});
    iniciar = 1;
    tick();
    iniciar = 0;
    tick();
    repeat (TO - 1) tick();
    chk("to_edge_wait", db_estado, 2);
    jogada_feita = 1;
    igual = 0;
    last_j = cyc;
    tick();
    jogada_feita = 0;
    chk("to_edge_registra", db_estado, 4);
    tick();
    tick();
    chk("to_edge_erro", {pronto, errou, timeout, db_estado}, {3'b110, 4'hE});
`else
    repeat (3 * TO) tick();
    chk("no_timeout", {pronto, timeout, db_estado}, {2'b00, 4'h2});
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
